// File: rtl/xras_pkg.sv
// xras_pkg: shared score type, alarm encoding and saturation ceiling for the XRAS history block
package xras_pkg;

    typedef logic [31:0] score_t;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        WARN   = 2'd1,
        CRIT   = 2'd2
    } xras_alarm_e;

    localparam int XRAS_SCORE_MAX = 1000;

endpackage

// File: rtl/xras_score_history_if.sv
// xras_score_history_if: score strobe/clear inputs and window/metric/alarm outputs of the history block
interface xras_score_history_if #(
    parameter int DEPTH = 16
);
    import xras_pkg::*;

    score_t                   score_in;
    logic                     score_valid;
    logic                     clear;
    score_t                   historical_scores [DEPTH];
    logic                     history_valid;
    logic [$clog2(DEPTH):0]   fill_count;
    score_t                   avg_score;
    xras_alarm_e              alarm_state;
    logic                     alarm_irq;
    score_t                   min_score;
    score_t                   max_score;

    modport master (
        output score_in, score_valid, clear,
        input  historical_scores, history_valid, fill_count, avg_score,
               alarm_state, alarm_irq, min_score, max_score
    );

    modport slave (
        input  score_in, score_valid, clear,
        output historical_scores, history_valid, fill_count, avg_score,
               alarm_state, alarm_irq, min_score, max_score
    );

endinterface

// File: rtl/xras_hist_minmax.sv
// xras_hist_minmax: pairwise min/max reduction tree over the DEPTH window entries
module xras_hist_minmax
    import xras_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  score_t scores [DEPTH],
    output score_t min_score,
    output score_t max_score
);

    // Halve the candidate set each level; in-place is safe because t[i] only reads t[2i], t[2i+1] >= i.
    function automatic score_t reduce(input score_t s [DEPTH], input logic want_max);
        score_t t [DEPTH];
        t = s;
        for (int w = DEPTH / 2; w >= 1; w = w / 2)
            for (int i = 0; i < w; i++)
                t[i] = ((t[2*i] > t[2*i+1]) == want_max) ? t[2*i] : t[2*i+1];
        return t[0];
    endfunction

    // Purely combinational; the top registers the results next to avg_score.
    always_comb begin
        min_score = reduce(scores, 1'b0);
        max_score = reduce(scores, 1'b1);
    end

endmodule

// File: rtl/xras_score_history.sv
// xras_score_history: sliding score window, running-sum average and NORMAL/WARN/CRIT alarm with hysteresis; optional window min/max under XRAS_HIST_MINMAX_EN
module xras_score_history
    import xras_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int SCORE_MAX = XRAS_SCORE_MAX,
    parameter int WARN_TH   = 700,
    parameter int CRIT_TH   = 400,
    parameter int HYST      = 50
) (
    input logic                 clk,
    input logic                 rst_n,
    xras_score_history_if.slave bus
);

    localparam int LOG = $clog2(DEPTH);
    localparam int SW  = 32 + LOG;
    localparam int CW  = LOG + 1;
    localparam score_t SMAX = score_t'(SCORE_MAX);
    localparam logic [SW-1:0] SUM_RST = SW'(DEPTH * SCORE_MAX);
    localparam score_t CT = score_t'(CRIT_TH);
    localparam score_t WT = score_t'(WARN_TH);
    localparam score_t CH = score_t'(CRIT_TH + HYST);
    localparam score_t WH = score_t'(WARN_TH + HYST);

    score_t        hist [DEPTH];
    logic [CW-1:0] fill;
    logic [SW-1:0] sum;
    logic          pend;
    logic          full;
    score_t        stored;
    score_t        avg;
    score_t        avg_nxt;
    xras_alarm_e   state;
    xras_alarm_e   state_nxt;
    logic          irq;
    logic          irq_nxt;

    assign stored  = (bus.score_in > SMAX) ? SMAX : bus.score_in;
    assign full    = (fill == CW'(DEPTH));
    assign avg_nxt = full ? sum[LOG +: 32] : hist[0];

    // Window shift, fill counter and incremental running sum; pend marks a metric update due next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= SMAX;
            fill <= '0;
            sum  <= SUM_RST;
            pend <= 1'b0;
        end else if (bus.clear) begin
            for (int i = 0; i < DEPTH; i++) hist[i] <= SMAX;
            fill <= '0;
            sum  <= SUM_RST;
            pend <= 1'b0;
        end else begin
            pend <= bus.score_valid;
            if (bus.score_valid) begin
                hist[0] <= stored;
                for (int i = 1; i < DEPTH; i++) hist[i] <= hist[i-1];
                fill <= full ? fill : fill + CW'(1);
                sum  <= sum + SW'(stored) - SW'(hist[DEPTH-1]);
            end
        end
    end

    // Alarm next state from the metric being registered this cycle; escalation raises irq.
    always_comb begin
        state_nxt = state;
        irq_nxt   = 1'b0;
        if (pend) begin
            case (state)
                NORMAL:  state_nxt = (avg_nxt < CT) ? CRIT : (avg_nxt < WT) ? WARN : NORMAL;
                WARN:    state_nxt = (avg_nxt < CT) ? CRIT : (avg_nxt >= WH) ? NORMAL : WARN;
                default: state_nxt = (avg_nxt >= WH) ? NORMAL : (avg_nxt >= CH) ? WARN : CRIT;
            endcase
            irq_nxt = (state_nxt > state);
        end
    end

    // Metric and alarm registers; clear also drops any metric update still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg   <= SMAX;
            state <= NORMAL;
            irq   <= 1'b0;
        end else if (bus.clear) begin
            avg   <= SMAX;
            state <= NORMAL;
            irq   <= 1'b0;
        end else begin
            state <= state_nxt;
            irq   <= irq_nxt;
            if (pend) avg <= avg_nxt;
        end
    end

    assign bus.historical_scores = hist;
    assign bus.history_valid     = full;
    assign bus.fill_count        = fill;
    assign bus.avg_score         = avg;
    assign bus.alarm_state       = state;
    assign bus.alarm_irq         = irq;

`ifdef XRAS_HIST_MINMAX_EN
    score_t mn_c;
    score_t mx_c;
    score_t mn;
    score_t mx;

    xras_hist_minmax #(.DEPTH(DEPTH)) u_minmax (
        .scores    (hist),
        .min_score (mn_c),
        .max_score (mx_c)
    );

    // Register the window extremes so they line up with avg_score.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mn <= SMAX;
            mx <= SMAX;
        end else if (bus.clear) begin
            mn <= SMAX;
            mx <= SMAX;
        end else begin
            mn <= mn_c;
            mx <= mx_c;
        end
    end

    assign bus.min_score = mn;
    assign bus.max_score = mx;
`else
    assign bus.min_score = SMAX;
    assign bus.max_score = SMAX;
`endif

endmodule

// File: tb/tb_xras_score_history.sv
// tb_xras_score_history: randomized and directed checks of the score history block against a window model
module tb_xras_score_history;
    import xras_pkg::*;

    localparam int DEPTH = 16;
    localparam int SMAX  = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xras_score_history_if #(.DEPTH(DEPTH)) bus ();

    xras_score_history #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int win[$];
    int m_fill, m_avg, m_state, m_irq, m_min, m_max;
    bit m_pend;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int wsum();
        int s = 0;
        foreach (win[i]) s += win[i];
        return s;
    endfunction

    function automatic int wmin();
        int m = win[0];
        foreach (win[i]) if (win[i] < m) m = win[i];
        return m;
    endfunction

    function automatic int wmax();
        int m = win[0];
        foreach (win[i]) if (win[i] > m) m = win[i];
        return m;
    endfunction

    function automatic int nxt(input int st, input int a);
        case (st)
            0:       return (a < 400) ? 2 : (a < 700) ? 1 : 0;
            1:       return (a < 400) ? 2 : (a >= 750) ? 0 : 1;
            default: return (a >= 750) ? 0 : (a >= 450) ? 1 : 2;
        endcase
    endfunction

    task automatic model_reset();
        win = {};
        for (int i = 0; i < DEPTH; i++) win.push_back(SMAX);
        m_fill = 0; m_pend = 0; m_avg = SMAX; m_state = 0; m_irq = 0;
        m_min = SMAX; m_max = SMAX;
    endtask

    task automatic check_all();
        chk("fill", bus.fill_count, m_fill);
        chk("hvalid", bus.history_valid, m_fill == DEPTH);
        chk("avg", bus.avg_score, m_avg);
        chk("state", bus.alarm_state, m_state);
        chk("irq", bus.alarm_irq, m_irq);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("hist%0d", i), bus.historical_scores[i], win[i]);
        chk("min", bus.min_score, m_min);
        chk("max", bus.max_score, m_max);
    endtask

    task automatic step(input bit v, input int s, input bit c);
        int a, ns;
        bus.score_valid = v;
        bus.score_in    = s;
        bus.clear       = c;
        @(posedge clk);
        if (c) model_reset();
        else begin
            m_irq = 0;
            if (m_pend) begin
                a = (m_fill == DEPTH) ? wsum() / DEPTH : win[0];
                ns = nxt(m_state, a);
                m_irq = ns > m_state;
                m_state = ns;
                m_avg = a;
            end
`ifdef XRAS_HIST_MINMAX_EN
            m_min = wmin();
            m_max = wmax();
`endif
            if (v) begin
                win.push_front(s > SMAX ? SMAX : s);
                void'(win.pop_back());
                if (m_fill < DEPTH) m_fill++;
            end
            m_pend = v;
        end
        @(negedge clk);
        bus.score_valid = 1'b0;
        bus.clear       = 1'b0;
        check_all();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int lvl;
        bus.score_in = '0; bus.score_valid = 1'b0; bus.clear = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_all();
        chk("t1_avg", bus.avg_score, 1000);

        for (int k = 0; k < DEPTH; k++) step(1, 800, 0);
        chk("t2_hvalid", bus.history_valid, 1);
        step(0, 0, 0);
        chk("t2_avg", bus.avg_score, 800);
        chk("t2_state", bus.alarm_state, NORMAL);

        for (int k = 0; k < DEPTH; k++) step(1, 1000, 0);
        step(0, 0, 0);
        for (int k = 1; k <= 14; k++) begin
            step(1, 300, 0);
            if (k == 8) begin
                chk("t3_avg693", bus.avg_score, 693);
                chk("t3_warn", bus.alarm_state, WARN);
                chk("t3_warn_irq", bus.alarm_irq, 1);
            end
        end
        step(0, 0, 0);
        chk("t3_avg387", bus.avg_score, 387);
        chk("t3_crit", bus.alarm_state, CRIT);
        chk("t3_crit_irq", bus.alarm_irq, 1);

        step(0, 0, 1);
        for (int k = 0; k < DEPTH; k++) step(1, 690, 0);
        for (int k = 0; k < DEPTH; k++) step(1, 720, 0);
        step(0, 0, 0);
        chk("t4_avg720", bus.avg_score, 720);
        chk("t4_stay_warn", bus.alarm_state, WARN);
        for (int k = 0; k < DEPTH; k++) step(1, 750, 0);
        step(0, 0, 0);
        chk("t4_avg750", bus.avg_score, 750);
        chk("t4_normal", bus.alarm_state, NORMAL);
        chk("t4_no_irq", bus.alarm_irq, 0);

        step(1, 5000, 0);
        chk("t5_sat", bus.historical_scores[0], 1000);
        for (int k = 0; k < 40; k++) step(1, $urandom_range(0, 1200), 0);
        step(0, 0, 0);
        chk("t5_wrap_avg", bus.avg_score, wsum() / DEPTH);

        step(1, 100, 1);
        chk("t6_fill", bus.fill_count, 0);
        chk("t6_hist0", bus.historical_scores[0], 1000);
        chk("t6_state", bus.alarm_state, NORMAL);

        lvl = 800;
        for (int k = 0; k < 400; k++) begin
            if (k % 20 == 0) lvl = $urandom_range(100, 1100);
            step($urandom_range(0, 9) < 7, lvl - 100 + $urandom_range(0, 200) +
                 (($urandom_range(0, 30) == 0) ? 4000 : 0), $urandom_range(0, 60) == 0);
        end

        for (int k = 0; k < DEPTH; k++) step(1, 1000, 0);
        step(1, 200, 0);
        step(1, 200, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0);
        chk("rst_no_irq", bus.alarm_irq, 0);
        step(0, 0, 0);
        chk("rst_avg", bus.avg_score, 1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
